// File: rtl/esfa_operand_loader.sv
// esfa_operand_loader: packs an 8-bit operand byte stream into 32-bit
// little-endian words and buffers them in a DEPTH-entry word FIFO.
// Optional feature: define ESFA_LOADER_PARITY_EN to enable the sticky
// even-parity check on accepted bytes (parity_err stays 0 otherwise).
module esfa_operand_loader #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  input  logic                         in_parity,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_last,
  output logic [2:0]                   out_bytes,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         parity_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [31:0]      mem_data  [DEPTH];
  logic [2:0]       mem_bytes [DEPTH];
  logic [DEPTH-1:0] mem_last;

  logic [1:0]       idx;
  logic [23:0]      part;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic [31:0]      word_c;
  logic [2:0]       word_bytes_c;
  logic [PTR_W-1:0] wr_next_c;
  logic [PTR_W-1:0] rd_next_c;
  logic [LVL_W-1:0] level_next_c;
  logic [31:0]      head_data_c;
  logic [2:0]       head_bytes_c;
  logic             head_last_c;

  // Handshake qualifiers and the word formed by inserting the current byte.
  always_comb begin
    accept_c     = in_valid & in_ready;
    push_c       = accept_c & ((idx == 2'd3) | in_last);
    pop_c        = out_valid & out_ready;
    word_c       = {8'h00, part};
    word_c[{idx, 3'b000} +: 8] = in_data;
    word_bytes_c = {1'b0, idx} + 3'd1;
  end

  // Next pointers, occupancy and the entry that will sit at the FIFO head.
  always_comb begin
    wr_next_c    = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_next_c    = pop_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_next_c = level;
    case ({push_c, pop_c})
      2'b10:   level_next_c = level + LVL_W'(1);
      2'b01:   level_next_c = level - LVL_W'(1);
      default: level_next_c = level;
    endcase
    head_data_c  = mem_data[rd_next_c];
    head_bytes_c = mem_bytes[rd_next_c];
    head_last_c  = mem_last[rd_next_c];
    // The slot being written this edge becomes the head when it is the only valid entry.
    if (push_c && (wr_ptr == rd_next_c)) begin
      head_data_c  = word_c;
      head_bytes_c = word_bytes_c;
      head_last_c  = in_last;
    end
  end

  // Packer, FIFO storage, pointers and registered output view of the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      part      <= 24'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_bytes <= 3'd0;
      out_last  <= 1'b0;
      mem_last  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i]  <= 32'h0;
        mem_bytes[i] <= 3'd0;
      end
    end else begin
      if (accept_c) begin
        if (push_c) begin
          idx  <= 2'd0;
          part <= 24'h0;
        end else begin
          idx  <= idx + 2'd1;
          part <= word_c[23:0];
        end
      end
      if (push_c) begin
        mem_data[wr_ptr]  <= word_c;
        mem_bytes[wr_ptr] <= word_bytes_c;
        mem_last[wr_ptr]  <= in_last;
      end
      wr_ptr    <= wr_next_c;
      rd_ptr    <= rd_next_c;
      level     <= level_next_c;
      in_ready  <= (level_next_c < LVL_W'(DEPTH));
      out_valid <= (level_next_c != '0);
      out_data  <= head_data_c;
      out_bytes <= head_bytes_c;
      out_last  <= head_last_c;
    end
  end

`ifdef ESFA_LOADER_PARITY_EN
  // Sticky flag: an accepted byte whose data plus parity bit has odd weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept_c && (^{in_data, in_parity})) begin
      parity_err <= 1'b1;
    end
  end
`else
  logic parity_unused;
  assign parity_unused = in_parity;
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_esfa_operand_loader.sv
// Testbench for esfa_operand_loader: random and directed byte streams,
// queue-based reference model and a negedge scoreboard monitor.
module tb_esfa_operand_loader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_parity;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_bytes;
  logic [2:0]  level;
  logic        parity_err;

  esfa_operand_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_bytes(out_bytes),
    .level(level), .parity_err(parity_err)
  );

  typedef struct {
    logic [31:0] data;
    int          bytes;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] part_q[$];
  logic       exp_perr;
  logic       armed;
  int         errors;
  int         checks;
  int         rdy_mode;   // 0 random, 1 hold low, 2 hold high

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // in_ready is only expected after the first clock edge out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Consumer-side ready pattern.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare DUT against model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_bytes", 32'(out_bytes), 32'd0);
      chk("rst_parity_err", 32'(parity_err), 32'd0);
      exp_q.delete();
      part_q.delete();
      exp_perr = 1'b0;
    end else begin
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(armed && (exp_q.size() < DEPTH)));
      chk("parity_err", 32'(parity_err), 32'(exp_perr));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_bytes", 32'(out_bytes), 32'(exp_q[0].bytes));
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        word_t w;
        part_q.push_back(in_data);
`ifdef ESFA_LOADER_PARITY_EN
        if ((^in_data) != in_parity) exp_perr = 1'b1;
`endif
        if (part_q.size() == 4 || in_last) begin
          w.data  = 32'h0;
          for (int i = 0; i < part_q.size(); i++) w.data[8*i +: 8] = part_q[i];
          w.bytes = part_q.size();
          w.last  = in_last;
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  end

  // Offer one byte and hold it until the loader takes it (bounded).
  task automatic send(input logic [7:0] d, input logic last, input logic par);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_parity = par;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] d, input logic last);
    send(d, last, ^d);
  endtask

  task automatic drain();
    bit done;
    done     = 1'b0;
    rdy_mode = 2;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (level == 0 && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(level), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit sender_done;

  initial begin
    errors    = 0;
    checks    = 0;
    rdy_mode  = 1;
    exp_perr  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_parity = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full word, then a short closing word.
    rdy_mode = 2;
    send_ok(8'h11, 1'b0); send_ok(8'h22, 1'b0); send_ok(8'h33, 1'b0); send_ok(8'h44, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send_ok(8'hAA, 1'b0); send_ok(8'hBB, 1'b1);
    drain();

    // Backpressure: fill the FIFO, check stall, then release.
    rdy_mode    = 1;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_ok(8'(i + 1), 1'b0);
        sender_done = 1'b1;
      end
    join_none
    repeat (40) @(negedge clk);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rdy_mode = 2;
    for (int c = 0; c < 200 && !sender_done; c++) @(posedge clk);
    if (!sender_done) chk("sender_timeout", 32'd0, 32'd1);
    #1;
    drain();

    // Level 2 then concurrent push/pop.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_ok(8'(8'h50 + i), 1'b0);
    @(negedge clk);
    chk("level_two", 32'(level), 32'd2);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_ok(8'h77, 1'b1);
    send_ok(8'h78, 1'b1);
    drain();

    // Reset mid-frame with stored words.
    rdy_mode = 1;
    for (int i = 0; i < 14; i++) send_ok(8'(8'hC0 + i), 1'b0);
    do_reset(3);
    rdy_mode = 2;
    send_ok(8'h01, 1'b0); send_ok(8'h02, 1'b0); send_ok(8'h03, 1'b0); send_ok(8'h04, 1'b1);
    drain();

    // Parity: bad byte is still packed and delivered.
    send(8'h03, 1'b1, 1'b1);
    drain();
    send_ok(8'h05, 1'b1);
    drain();

    // Random traffic.
    rdy_mode = 0;
    for (int n = 0; n < 400; n++) begin
      send_ok(8'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send_ok(8'hEE, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esfa_operand_loader.md
ESFA_OPERAND_LOADER -- requirements
Module: esfa_operand_loader

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, word-FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_ready  output  1  loader accepts byte this cycle.
REQ-006 in_data  input  8  operand byte.
REQ-007 in_last  input  1  byte is final byte of frame.
REQ-008 in_parity  input  1  even-parity bit for in_data.
REQ-009 out_valid  output  1  word available to the ESFA core.
REQ-010 out_ready  input  1  ESFA core takes word this cycle.
REQ-011 out_data  output  32  packed operand word.
REQ-012 out_last  output  1  word closes a frame.
REQ-013 out_bytes  output  3  valid byte count in out_data, 1..4.
REQ-014 level  output  clog2(DEPTH)+1  words currently stored.
REQ-015 parity_err  output  1  sticky parity-error flag.

Function
REQ-016 A byte SHALL transfer only on a rising edge with in_valid and in_ready both high.
REQ-017 in_ready SHALL be high iff level < DEPTH; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-018 Packer SHALL keep byte index 0..3; accepted byte written to bits [8*idx+7:8*idx] (first byte at [7:0], little-endian).
REQ-019 A word SHALL complete when the byte at idx 3 is accepted or a byte with in_last=1 is accepted; unfilled upper bytes SHALL be zero.
REQ-020 On completion the word, out_bytes=idx+1 and out_last=in_last SHALL be pushed into the FIFO at that same edge; idx returns to 0.
REQ-021 Latency: a completed word SHALL appear at the FIFO head with out_valid high on the cycle after its completing byte is accepted; no combinational bypass.
REQ-022 out_valid SHALL be high iff level > 0; out_data/out_last/out_bytes SHALL present the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-023 A word SHALL pop on an edge with out_valid and out_ready high.
REQ-024 Simultaneous push and pop SHALL leave level unchanged, and both SHALL occur.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; full is level==DEPTH, empty is level==0.
REQ-026 out_valid=0 with out_ready=1 SHALL have no effect; in_valid=0 SHALL not advance idx.

Reset
REQ-027 While rst_n=0: level=0, idx=0, pointers=0, out_valid=0, in_ready=0, out_data=0, out_last=0, out_bytes=0, parity_err=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word and all stored words; first byte after release goes to idx 0.
REQ-029 in_ready SHALL rise on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With ESFA_LOADER_PARITY_EN defined, each accepted byte SHALL be checked: XOR(in_data, in_parity)!=0 sets parity_err at that edge, held until reset; the byte is still packed.
REQ-031 Without ESFA_LOADER_PARITY_EN, in_parity SHALL be ignored and parity_err SHALL be constant 0.

Verification
REQ-032 Bytes 11,22,33,44 (last on 44), out_ready=1 -> one word 0x44332211, out_bytes=4, out_last=1, out_valid one cycle after 4th byte.
REQ-033 Bytes AA,BB with last on BB -> out_data=0x0000BBAA, out_bytes=2, out_last=1.
REQ-034 out_ready=0, stream 20 bytes, DEPTH=4 -> level reaches 4, in_ready drops after 16th byte, data held stable; release out_ready -> words in order, pointers wrap correctly.
REQ-035 Level=2, push and pop on same edge -> level stays 2, order preserved.
REQ-036 Assert rst_n low after 2 bytes of a frame and 3 stored words -> all outputs per REQ-027; next frame 01,02,03,04 -> 0x04030201.
REQ-037 Macro defined, byte 0x03 with in_parity=1 -> parity_err=1 sticky, word delivered; macro undefined, same stimulus -> parity_err=0.
